// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI4-Lite master sequencer.
// Response codes, abort causes, engine states and small helpers.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_RETRY   = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_code_t;

  typedef enum logic [2:0] {
    R_IDLE,
    R_AR,
    R_R,
    R_DONE,
    R_FAIL
  } r_state_t;

  typedef enum logic [2:0] {
    W_IDLE,
    W_SEND,
    W_B,
    W_DONE,
    W_FAIL
  } w_state_t;

  localparam int STAT_W = 16;

  // SLVERR and DECERR both count as a failed beat
  function automatic logic resp_is_err(input logic [1:0] r);
    resp_t rr;
    rr = resp_t'(r);
    return (rr == SLVERR) || (rr == DECERR);
  endfunction

  // Saturating add of a 0..2 increment
  function automatic logic [STAT_W-1:0] sat_add(
    input logic [STAT_W-1:0] a,
    input logic [1:0]        b
  );
    logic [STAT_W:0] s;
    s = {1'b0, a} + {{(STAT_W-1){1'b0}}, b};
    return s[STAT_W] ? {STAT_W{1'b1}} : s[STAT_W-1:0];
  endfunction

endpackage

// File: rtl/axi_lite_wdog.sv
// Per-transaction watchdog: counts while run is high,
// reloads on kick, flags expiry on the TIMEOUT_CYC-th cycle.
module axi_lite_wdog #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic kick,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  assign expired = run && !kick && (cnt == LAST);

  // Cycle counter, cleared when idle or on any handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!run || kick) begin
      cnt <= '0;
    end else if (!expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/axi_lite_master_ctrl.sv
// AXI4-Lite master: independent read/write engines with retry and watchdog.
// Define AXI_LITE_MASTER_STATS_EN to add saturating retry/timeout counters.
module axi_lite_master_ctrl
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_RETRY   = 10,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                re,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [DATA_W-1:0]   rdata,
  output logic                r_done,
  output logic                r_err,
  output logic                r_busy,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic                w_done,
  output logic                w_err,
  output logic                w_busy,
  output logic [1:0]          err_code,
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata_i,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
`ifdef AXI_LITE_MASTER_STATS_EN
  output logic [STAT_W-1:0]   stat_rd_retry,
  output logic [STAT_W-1:0]   stat_wr_retry,
  output logic [STAT_W-1:0]   stat_timeout,
`endif
  output logic                bready
);

  localparam logic [7:0] MAXR = 8'(MAX_RETRY);

  r_state_t r_state, r_nxt;
  w_state_t w_state, w_nxt;

  logic [ADDR_W-1:0]   raddr_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;

  logic [7:0] r_retry, w_retry;
  logic [7:0] r_retry_inc, w_retry_inc;

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic aw_ok, w_ok, aw_ok_n, w_ok_n;
  logic r_run, r_kick, r_to;
  logic w_run, w_kick, w_to;
  logic r_retry_ev, r_ab_retry, r_ab_to;
  logic w_retry_ev, w_ab_retry, w_ab_to;

  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid && rready;
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign b_hs  = bvalid && bready;

  assign aw_ok_n = aw_ok || aw_hs;
  assign w_ok_n  = w_ok || w_hs;

  assign r_retry_inc = r_retry + 8'd1;
  assign w_retry_inc = w_retry + 8'd1;

  assign arvalid = (r_state == R_AR);
  assign rready  = (r_state == R_R);
  assign r_done  = (r_state == R_DONE);
  assign r_err   = (r_state == R_FAIL);
  assign r_busy  = (r_state != R_IDLE);
  assign araddr  = raddr_q;

  assign awvalid = (w_state == W_SEND) && !aw_ok;
  assign wvalid  = (w_state == W_SEND) && !w_ok;
  assign bready  = (w_state == W_B);
  assign w_done  = (w_state == W_DONE);
  assign w_err   = (w_state == W_FAIL);
  assign w_busy  = (w_state != W_IDLE);
  assign awaddr  = waddr_q;
  assign wdata_o = wdata_q;
  assign wstrb_o = wstrb_q;

  assign r_run  = (r_state == R_AR) || (r_state == R_R);
  assign r_kick = ar_hs || r_hs;
  assign w_run  = (w_state == W_SEND) || (w_state == W_B);
  assign w_kick = aw_hs || w_hs || b_hs;

  axi_lite_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_r_wdog (
    .clk     (clk),
    .rst     (rst),
    .run     (r_run),
    .kick    (r_kick),
    .expired (r_to)
  );

  axi_lite_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_w_wdog (
    .clk     (clk),
    .rst     (rst),
    .run     (w_run),
    .kick    (w_kick),
    .expired (w_to)
  );

  // Read engine state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_nxt;
  end

  // Read engine next state and abort/retry events
  always_comb begin
    r_nxt      = r_state;
    r_retry_ev = 1'b0;
    r_ab_retry = 1'b0;
    r_ab_to    = 1'b0;
    unique case (r_state)
      R_IDLE: if (re) r_nxt = R_AR;
      R_AR: begin
        if (r_to) begin
          r_nxt   = R_FAIL;
          r_ab_to = 1'b1;
        end else if (ar_hs) begin
          r_nxt = R_R;
        end
      end
      R_R: begin
        if (r_to) begin
          r_nxt   = R_FAIL;
          r_ab_to = 1'b1;
        end else if (r_hs) begin
          if (!resp_is_err(rresp)) begin
            r_nxt = R_DONE;
          end else if (r_retry_inc < MAXR) begin
            r_nxt      = R_AR;
            r_retry_ev = 1'b1;
          end else begin
            r_nxt      = R_FAIL;
            r_ab_retry = 1'b1;
          end
        end
      end
      R_DONE:  r_nxt = R_IDLE;
      R_FAIL:  r_nxt = R_IDLE;
      default: r_nxt = R_IDLE;
    endcase
  end

  // Read address latch, data capture and retry count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raddr_q <= '0;
      rdata   <= '0;
      r_retry <= '0;
    end else begin
      if (r_state == R_IDLE && re) raddr_q <= raddr;
      if (r_state == R_R && r_hs && !resp_is_err(rresp))
        rdata <= rdata_i;
      if (r_retry_ev)   r_retry <= r_retry_inc;
      else if (!r_run)  r_retry <= '0;
    end
  end

  // Write engine state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_nxt;
  end

  // Write engine next state and abort/retry events
  always_comb begin
    w_nxt      = w_state;
    w_retry_ev = 1'b0;
    w_ab_retry = 1'b0;
    w_ab_to    = 1'b0;
    unique case (w_state)
      W_IDLE: if (we) w_nxt = W_SEND;
      W_SEND: begin
        if (w_to) begin
          w_nxt   = W_FAIL;
          w_ab_to = 1'b1;
        end else if (aw_ok_n && w_ok_n) begin
          w_nxt = W_B;
        end
      end
      W_B: begin
        if (w_to) begin
          w_nxt   = W_FAIL;
          w_ab_to = 1'b1;
        end else if (b_hs) begin
          if (!resp_is_err(bresp)) begin
            w_nxt = W_DONE;
          end else if (w_retry_inc < MAXR) begin
            w_nxt      = W_SEND;
            w_retry_ev = 1'b1;
          end else begin
            w_nxt      = W_FAIL;
            w_ab_retry = 1'b1;
          end
        end
      end
      W_DONE:  w_nxt = W_IDLE;
      W_FAIL:  w_nxt = W_IDLE;
      default: w_nxt = W_IDLE;
    endcase
  end

  // Write payload latch, per-channel handshake flags, retry count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      aw_ok   <= 1'b0;
      w_ok    <= 1'b0;
      w_retry <= '0;
    end else begin
      if (w_state == W_IDLE && we) begin
        waddr_q <= waddr;
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      if (w_state == W_SEND) begin
        aw_ok <= aw_ok_n;
        w_ok  <= w_ok_n;
      end else begin
        aw_ok <= 1'b0;
        w_ok  <= 1'b0;
      end
      if (w_retry_ev)   w_retry <= w_retry_inc;
      else if (!w_run)  w_retry <= '0;
    end
  end

  // Last abort cause; write wins a same-cycle tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_code <= ERR_NONE;
    end else if (w_ab_to) begin
      err_code <= ERR_TIMEOUT;
    end else if (w_ab_retry) begin
      err_code <= ERR_RETRY;
    end else if (r_ab_to) begin
      err_code <= ERR_TIMEOUT;
    end else if (r_ab_retry) begin
      err_code <= ERR_RETRY;
    end
  end

`ifdef AXI_LITE_MASTER_STATS_EN
  // Saturating event counters, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_rd_retry <= '0;
      stat_wr_retry <= '0;
      stat_timeout  <= '0;
    end else begin
      stat_rd_retry <= sat_add(stat_rd_retry, {1'b0, r_retry_ev});
      stat_wr_retry <= sat_add(stat_wr_retry, {1'b0, w_retry_ev});
      stat_timeout  <= sat_add(stat_timeout,
                               {1'b0, r_ab_to} + {1'b0, w_ab_to});
    end
  end
`endif

endmodule

// File: tb/tb_axi_lite_master_ctrl.sv
// Directed bench for axi_lite_master_ctrl with a small AXI-Lite slave.
// MAX_RETRY=10, TIMEOUT_CYC=16.
module tb_axi_lite_master_ctrl;

  logic        clk;
  logic        rst;
  logic        re;
  logic [31:0] raddr;
  logic [31:0] rdata;
  logic        r_done, r_err, r_busy;
  logic        we;
  logic [31:0] waddr, wdata;
  logic [3:0]  wstrb;
  logic        w_done, w_err, w_busy;
  logic [1:0]  err_code;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata_i;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic [31:0] awaddr;
  logic        awvalid, awready;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  logic        ar_en, aw_en, w_en, b_hold, b_err_forever, clr;
  int          r_err_cfg;
  int          r_err_seen, ar_cnt, aw_cnt, w_cnt;
  logic [31:0] rd_val;
  logic        aw_got, w_got;

  int n_assert = 0;
  int n_fail   = 0;

  axi_lite_master_ctrl #(
    .ADDR_W(32), .DATA_W(32), .MAX_RETRY(10), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst(rst),
    .re(re), .raddr(raddr), .rdata(rdata),
    .r_done(r_done), .r_err(r_err), .r_busy(r_busy),
    .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .w_done(w_done), .w_err(w_err), .w_busy(w_busy),
    .err_code(err_code),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata_i(rdata_i), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign arready = ar_en;
  assign awready = aw_en;
  assign wready  = w_en;

  // Slave: R one cycle after AR; B one cycle after both AW and W
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid  <= 1'b0;
      rresp   <= 2'b00;
      rdata_i <= '0;
      bvalid  <= 1'b0;
      bresp   <= 2'b00;
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
    end else begin
      if (rvalid && rready) rvalid <= 1'b0;
      if (arvalid && arready) begin
        rvalid  <= 1'b1;
        rdata_i <= rd_val;
        rresp   <= (r_err_seen < r_err_cfg) ? 2'b10 : 2'b00;
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if ((aw_got || (awvalid && awready)) &&
          (w_got || (wvalid && wready)) && !bvalid && !b_hold) begin
        bvalid <= 1'b1;
        bresp  <= b_err_forever ? 2'b10 : 2'b00;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        aw_got <= aw_got || (awvalid && awready);
        w_got  <= w_got || (wvalid && wready);
      end
    end
  end

  // Handshake counters
  always @(posedge clk) begin
    if (clr) begin
      ar_cnt     <= 0;
      aw_cnt     <= 0;
      w_cnt      <= 0;
      r_err_seen <= 0;
    end else begin
      if (arvalid && arready) begin
        ar_cnt <= ar_cnt + 1;
        if (r_err_seen < r_err_cfg) r_err_seen <= r_err_seen + 1;
      end
      if (awvalid && awready) aw_cnt <= aw_cnt + 1;
      if (wvalid && wready)   w_cnt  <= w_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int ndone, nerr, n;
    logic [1:0] ec;
    rst = 1'b1; re = 0; we = 0; raddr = 0; waddr = 0; wdata = 0; wstrb = 0;
    ar_en = 1; aw_en = 1; w_en = 1; b_hold = 0; b_err_forever = 0;
    r_err_cfg = 0; clr = 1; rd_val = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_busy", {r_busy, w_busy}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err_code", err_code, 0);
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1 clr = 0;

    // 1: read, always-ready slave, OKAY
    rd_val = 32'hDEADBEEF; re = 1; raddr = 32'h1000;
    @(posedge clk); #1 re = 0;
    @(negedge clk);
    chk("t1_arvalid", arvalid, 1);
    chk("t1_araddr", araddr, 32'h1000);
    @(posedge clk); @(negedge clk);
    chk("t1_rdone_early", r_done, 0);
    chk("t1_rready", rready, 1);
    @(posedge clk); @(negedge clk);
    chk("t1_rdone", r_done, 1);
    chk("t1_rdata", rdata, 32'hDEADBEEF);
    @(posedge clk); @(negedge clk);
    chk("t1_rdone_pulse", r_done, 0);
    chk("t1_rbusy", r_busy, 0);

    // 2: write, awready two cycles ahead of wready
    @(posedge clk); #1
    aw_en = 1; w_en = 0; clr = 1; we = 1;
    waddr = 32'h2000; wdata = 32'hA5A50F0F; wstrb = 4'b0110;
    @(posedge clk); #1 we = 0; clr = 0;
    @(negedge clk);
    chk("t2_both_valid", {awvalid, wvalid}, 2'b11);
    chk("t2_awaddr", awaddr, 32'h2000);
    chk("t2_wdata", wdata_o, 32'hA5A50F0F);
    chk("t2_wstrb", wstrb_o, 4'b0110);
    @(posedge clk); @(negedge clk);
    chk("t2_aw_first", {awvalid, wvalid}, 2'b01);
    @(posedge clk); #1 w_en = 1;
    @(negedge clk);
    chk("t2_wvalid_held", wvalid, 1);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (w_done) ndone++;
    end
    chk("t2_wdone_count", ndone, 1);
    chk("t2_aw_count", aw_cnt, 1);
    chk("t2_w_count", w_cnt, 1);
    chk("t2_wbusy", w_busy, 0);

    // 3: read with three SLVERR then OKAY
    @(posedge clk); #1
    clr = 1; r_err_cfg = 3; rd_val = 32'h0BADF00D; re = 1; raddr = 32'h3000;
    @(posedge clk); #1 re = 0; clr = 0;
    ndone = 0; nerr = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (r_done) ndone++;
      if (r_err) nerr++;
      if (r_done || r_err) break;
    end
    chk("t3_rdone", ndone, 1);
    chk("t3_rerr", nerr, 0);
    chk("t3_ar_count", ar_cnt, 4);
    chk("t3_rdata", rdata, 32'h0BADF00D);
    r_err_cfg = 0;

    // 4: write with SLVERR forever
    @(posedge clk); #1
    clr = 1; b_err_forever = 1; we = 1;
    waddr = 32'h4000; wdata = 32'h11223344; wstrb = 4'hF;
    @(posedge clk); #1 we = 0; clr = 0;
    ndone = 0; nerr = 0; ec = 2'b00;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (w_done) ndone++;
      if (w_err) begin
        nerr++;
        ec = err_code;
        break;
      end
    end
    chk("t4_werr", nerr, 1);
    chk("t4_wdone", ndone, 0);
    chk("t4_err_code", ec, 2'b01);
    chk("t4_aw_count", aw_cnt, 10);
    chk("t4_w_count", w_cnt, 10);
    b_err_forever = 0;
    @(negedge clk);
    chk("t4_wbusy", w_busy, 0);

    // 5: arready never asserted -> timeout after 16 cycles
    @(posedge clk); #1 ar_en = 0; re = 1; raddr = 32'h5000;
    @(posedge clk); #1 re = 0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!arvalid) break;
      n++;
    end
    chk("t5_arvalid_cycles", n, 16);
    chk("t5_rerr", r_err, 1);
    chk("t5_err_code", err_code, 2'b10);
    @(negedge clk);
    chk("t5_rbusy", r_busy, 0);
    chk("t5_arvalid_low", arvalid, 0);
    ar_en = 1;

    // 6: reset while waiting for B, then a clean write
    @(posedge clk); #1 b_hold = 1; we = 1;
    waddr = 32'h6000; wdata = 32'h55AA55AA; wstrb = 4'hF;
    @(posedge clk); #1 we = 0;
    @(posedge clk); @(negedge clk);
    chk("t6_bready", bready, 1);
    #1 rst = 1;
    #1;
    chk("t6_rst_bready", bready, 0);
    chk("t6_rst_valids", {awvalid, wvalid, arvalid, rready}, 0);
    chk("t6_rst_busy", {w_busy, r_busy}, 0);
    chk("t6_rst_err_code", err_code, 0);
    @(posedge clk); #1 rst = 0; b_hold = 0;
    @(posedge clk); #1 we = 1;
    waddr = 32'h7000; wdata = 32'hCAFEF00D; wstrb = 4'hF;
    @(posedge clk); #1 we = 0;
    @(negedge clk);
    chk("t6_wdata", wdata_o, 32'hCAFEF00D);
    @(posedge clk); @(negedge clk);
    chk("t6_wdone_early", w_done, 0);
    @(posedge clk); @(negedge clk);
    chk("t6_wdone", w_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
